// File: rtl/mb_ctrl_pkg.sv
// rtl/mb_ctrl_pkg.sv - shared states and sizing constants for the bank scan controller
package mb_ctrl_pkg;

    localparam int MB_NUM_BANKS = 13;
    localparam int MB_IDX_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_PROC = 2'd2,
        ST_DONE = 2'd3
    } mb_state_t;

endpackage

// File: rtl/mb_scan_controller_if.sv
// rtl/mb_scan_controller_if.sv - control and bank-read handshake bundle for the scan controller
interface mb_scan_controller_if #(
    parameter int IDX_W = mb_ctrl_pkg::MB_IDX_W
);
    logic             start;
    logic             abort;
    logic             rd_ack;
    logic             rd_req;
    logic [IDX_W-1:0] rd_addr;
    logic             proc_en;
    logic             last;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, rd_ack,
        input  rd_req, rd_addr, proc_en, last, busy, done
    );

    modport slave (
        input  start, abort, rd_ack,
        output rd_req, rd_addr, proc_en, last, busy, done
    );
endinterface

// File: rtl/mb_index_counter.sv
// rtl/mb_index_counter.sv - mod-NUM_BANKS bank index counter with explicit wrap
import mb_ctrl_pkg::*;

module mb_index_counter #(
    parameter int NUM_BANKS = MB_NUM_BANKS,
    parameter int IDX_W     = MB_IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [IDX_W-1:0] count,
    output logic             wrap
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BANKS - 1);

    assign wrap = (count == LAST_IDX);

    // Clear wins over increment; wrap is decoded, never left to overflow.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end
endmodule

// File: rtl/mb_scan_controller.sv
// rtl/mb_scan_controller.sv - walks bank indices 0..NUM_BANKS-1 once per start with read/ack/process steps
import mb_ctrl_pkg::*;

module mb_scan_controller #(
    parameter int NUM_BANKS = MB_NUM_BANKS,
    parameter int IDX_W     = MB_IDX_W
) (
    input  logic                  clk,
    input  logic                  rst,
    mb_scan_controller_if.slave   bus
);
    mb_state_t        state_q;
    mb_state_t        state_d;
    logic             idx_clr;
    logic             idx_inc;
    logic             idx_wrap;
    logic [IDX_W-1:0] idx;

    mb_index_counter #(
        .NUM_BANKS (NUM_BANKS),
        .IDX_W     (IDX_W)
    ) u_index (
        .clk   (clk),
        .rst   (rst),
        .clr   (idx_clr),
        .inc   (idx_inc),
        .count (idx),
        .wrap  (idx_wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Abort outranks ack and index advance in every active state.
    always_comb begin
        state_d = state_q;
        idx_clr = 1'b0;
        idx_inc = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_REQ;
                    idx_clr = 1'b1;
                end
            end
            ST_REQ: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                    idx_clr = 1'b1;
                end else if (bus.rd_ack) begin
                    state_d = ST_PROC;
                end
            end
            ST_PROC: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                    idx_clr = 1'b1;
                end else begin
                    idx_inc = 1'b1;
                    state_d = idx_wrap ? ST_DONE : ST_REQ;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                idx_clr = bus.abort;
            end
            default: begin
                state_d = ST_IDLE;
                idx_clr = 1'b1;
            end
        endcase
    end

    // Outputs depend only on registered state and index.
    assign bus.rd_req  = (state_q == ST_REQ);
    assign bus.proc_en = (state_q == ST_PROC);
    assign bus.done    = (state_q == ST_DONE);
    assign bus.busy    = (state_q != ST_IDLE);
    assign bus.last    = idx_wrap && ((state_q == ST_REQ) || (state_q == ST_PROC));
    assign bus.rd_addr = idx;
endmodule
